// File: rtl/banco_pkg.sv
// Shared constants and types for the general-purpose register bank.
// Build option: define BANCO_BYPASS_EN to enable write-through read forwarding.
package banco_pkg;

    localparam int N_REGS = 32;
    localparam int DATA_W = 4;
    localparam int ADDR_W = $clog2(N_REGS);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/banco_reg_cell.sv
// One storage word of the register bank: synchronous active-low clear,
// load enable, no other behaviour.
module banco_reg_cell #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/banco_de_registros.sv
// Register file: 2 combinational read ports, 1 synchronous write port, r0 = 0.
// Build option: BANCO_BYPASS_EN forwards data_in to a read port addressing the
// register being written in the same cycle.
module banco_de_registros
    import banco_pkg::*;
#(
    parameter int N = N_REGS,
    parameter int W = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] addr_rd,
    input  logic [W-1:0]         data_in,
    input  logic [$clog2(N)-1:0] addr_rs1,
    input  logic [$clog2(N)-1:0] addr_rs2,
    output logic [W-1:0]         rs1,
    output logic [W-1:0]         rs2
);

    localparam int AW = $clog2(N);

    logic [W-1:0] regs [N];

    // Index 0 has no storage; it is a constant so writes to it vanish.
    assign regs[0] = '0;

    for (genvar i = 1; i < N; i++) begin : g_cell
        banco_reg_cell #(
            .W(W)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .ld (we && (addr_rd == AW'(i))),
            .d  (data_in),
            .q  (regs[i])
        );
    end

`ifdef BANCO_BYPASS_EN
    logic wr_live;
    assign wr_live = we && rst && (addr_rd != '0);

    assign rs1 = (wr_live && (addr_rs1 == addr_rd)) ? data_in : regs[addr_rs1];
    assign rs2 = (wr_live && (addr_rs2 == addr_rd)) ? data_in : regs[addr_rs2];
`else
    assign rs1 = regs[addr_rs1];
    assign rs2 = regs[addr_rs2];
`endif

endmodule

// File: tb/tb_banco_de_registros.sv
// Self-checking bench for banco_de_registros against an array-based reference
// model; follows BANCO_BYPASS_EN if defined.
module tb_banco_de_registros;

    localparam int N  = 32;
    localparam int W  = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] addr_rd;
    logic [W-1:0]  data_in;
    logic [AW-1:0] addr_rs1;
    logic [AW-1:0] addr_rs2;
    logic [W-1:0]  rs1;
    logic [W-1:0]  rs2;

    logic [W-1:0]  model [N];
    int            checks   = 0;
    int            failures = 0;

    banco_de_registros #(
        .N(N),
        .W(W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .addr_rd (addr_rd),
        .data_in (data_in),
        .addr_rs1(addr_rs1),
        .addr_rs2(addr_rs2),
        .rs1     (rs1),
        .rs2     (rs2)
    );

    always #5 clk = ~clk;

    // What a read of address a should return right now, from the stored
    // contents plus (optionally) the write currently being presented.
    function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
`ifdef BANCO_BYPASS_EN
        if (we && rst && (addr_rd != 0) && (a == addr_rd)) return data_in;
`endif
        if (a == 0) return '0;
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_rs1"}, rs1, exp_read(addr_rs1));
        check({tag, "_rs2"}, rs2, exp_read(addr_rs2));
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [AW-1:0] other);
        we       = 1'b1;
        addr_rd  = a;
        data_in  = d;
        addr_rs1 = a;
        addr_rs2 = other;
        #1;
        check_ports("pre_edge");
        @(posedge clk);
        if (rst && a != 0) model[a] = d;
        #1;
        we = 1'b0;
        #1;
        check_ports("post_edge");
    endtask

    initial begin
        rst      = 1'b0;
        we       = 1'b0;
        addr_rd  = '0;
        data_in  = '0;
        addr_rs1 = '0;
        addr_rs2 = '0;

        // Reset
        @(posedge clk);
        clear_model();
        #1;
        rst = 1'b1;
        for (int a = 0; a < N; a++) begin
            addr_rs1 = AW'(a);
            addr_rs2 = AW'(N - 1 - a);
            #1;
            check("reset_rs1", rs1, 4'h0);
            check("reset_rs2", rs2, 4'h0);
        end

        // Directed writes then reads
        do_write(5'd5, 4'h3, 5'd17);
        do_write(5'd17, 4'hA, 5'd5);
        addr_rs1 = 5'd5;
        addr_rs2 = 5'd17;
        #1;
        check("wr_rd_rs1", rs1, 4'h3);
        check("wr_rd_rs2", rs2, 4'hA);

        // Write-enable gating
        we      = 1'b0;
        addr_rd = 5'd5;
        data_in = 4'hF;
        @(posedge clk);
        #1;
        addr_rs1 = 5'd5;
        #1;
        check("we_gate", rs1, 4'h3);

        // Zero register
        do_write(5'd0, 4'hF, 5'd0);
        addr_rs1 = 5'd0;
        #1;
        check("zero_reg", rs1, 4'h0);

`ifdef BANCO_BYPASS_EN
        we       = 1'b1;
        addr_rd  = 5'd12;
        data_in  = 4'h6;
        addr_rs1 = 5'd12;
        addr_rs2 = 5'd12;
        #1;
        check("bypass_rs1", rs1, 4'h6);
        check("bypass_rs2", rs2, 4'h6);
        @(posedge clk);
        model[12] = 4'h6;
        #1;
        we = 1'b0;
`endif

        // Reset overrides a simultaneous write
        rst     = 1'b0;
        we      = 1'b1;
        addr_rd = 5'd9;
        data_in = 4'h7;
        @(posedge clk);
        clear_model();
        #1;
        rst = 1'b1;
        we  = 1'b0;
        addr_rs1 = 5'd9;
        addr_rs2 = 5'd5;
        #1;
        check("rst_prio_r9", rs1, 4'h0);
        check("rst_prio_r5", rs2, 4'h0);
        addr_rs1 = 5'd17;
        #1;
        check("rst_prio_r17", rs1, 4'h0);

        // Random sweep
        for (int i = 0; i < 31; i++) begin
            do_write(AW'($urandom_range(31, 0)), W'($urandom_range(15, 0)),
                     AW'($urandom_range(31, 0)));
        end
        for (int i = 0; i < 31; i++) begin
            addr_rs1 = AW'($urandom_range(31, 0));
            addr_rs2 = AW'($urandom_range(31, 0));
            #2;
            check_ports("rand_rd");
            #3;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
